// File: rtl/x86_prefetch_queue_pkg.sv
// ============================================================================
// x86_prefetch_queue_pkg : shared FSM encodings, address width, helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package x86_prefetch_queue_pkg;

  localparam int PF_AW = 20;

  typedef enum logic [0:0] {
    PF_FETCH = 1'b0,
    PF_GRANT = 1'b1
  } pf_state_e;

  // 8086 real-mode linear address: segment*16 + offset, truncated to 20 bits
  function automatic logic [PF_AW-1:0] lin_addr(input logic [15:0] seg,
                                                input logic [15:0] off);
    return PF_AW'({seg, 4'h0}) + PF_AW'(off);
  endfunction

endpackage

`default_nettype wire

// File: rtl/x86_prefetch_queue_if.sv
// ============================================================================
// x86_prefetch_queue_if : decoder, EU and memory-bus signals of the prefetcher
// Revision 1.0
// ============================================================================
`default_nettype none

interface x86_prefetch_queue_if #(
  parameter int AW = x86_prefetch_queue_pkg::PF_AW
);
  logic          flush;
  logic [AW-1:0] flush_addr;
  logic [7:0]    q_data;
  logic          q_valid;
  logic          q_ready;
  logic          eu_req;
  logic [AW-1:0] eu_address;
  logic          eu_gnt;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_i_data;

  // master: the prefetch queue itself, which owns the memory port
  modport master (
    input  flush, flush_addr, q_ready, eu_req, eu_address, mem_i_data,
    output q_data, q_valid, eu_gnt, mem_address
  );

  modport slave (
    output flush, flush_addr, q_ready, eu_req, eu_address, mem_i_data,
    input  q_data, q_valid, eu_gnt, mem_address
  );
endinterface

`default_nettype wire

// File: rtl/x86_prefetch_queue_pfq_fifo.sv
// ============================================================================
// pfq_fifo : DEPTH x 8 circular byte buffer with push/pop/clear
// Revision 1.0
// ============================================================================
`default_nettype none

module pfq_fifo #(
  parameter  int DEPTH = 6,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  input  wire logic          clear_i,
  input  wire logic          push_i,
  input  wire logic          pop_i,
  input  wire logic [7:0]    data_i,
  output      logic [7:0]    data_o,
  output      logic [CW-1:0] count_o
);
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  // A full buffer accepts a push only when the head leaves in the same cycle
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= ptr_inc(tail_q);
      if (do_pop)  head_q <= ptr_inc(head_q);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[tail_q] <= data_i;
  end

  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/x86_prefetch_queue.sv
// ============================================================================
// x86_prefetch_queue : opcode prefetch FIFO + memory-port arbiter (EU first)
// Revision 1.0   optional statistics: `define PREFETCH_STATS_EN
// ============================================================================
`default_nettype none

module x86_prefetch_queue
  import x86_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int AW    = PF_AW
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  x86_prefetch_queue_if.master  bus
`ifdef PREFETCH_STATS_EN
  ,
  output      logic [15:0]      stat_flush,
  output      logic [15:0]      stat_starve
`endif
);
  localparam int CW = $clog2(DEPTH + 1);

  pf_state_e     state_q, state_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic          inflight_q, inflight_d;
  logic          issue;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;

  // Bytes already queued plus the one on its way back from memory
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight_q);
  assign pop       = bus.q_ready && bus.q_valid;

  assign bus.q_valid     = (count != '0);
  assign bus.eu_gnt      = (state_q == PF_GRANT);
  assign bus.mem_address = bus.eu_gnt ? bus.eu_address : fetch_addr_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    issue        = 1'b0;
    case (state_q)
      PF_FETCH: begin
        issue = !bus.eu_req && !bus.flush && (occupancy < (CW + 1)'(DEPTH));
        // An outstanding fetch must return before the EU may take the port
        if (bus.eu_req && !inflight_q) state_d = PF_GRANT;
      end
      PF_GRANT: begin
        if (!bus.eu_req) state_d = PF_FETCH;
      end
      default: state_d = PF_FETCH;
    endcase
    if (bus.flush)  fetch_addr_d = bus.flush_addr;
    else if (issue) fetch_addr_d = fetch_addr_q + AW'(1);
    inflight_d = issue;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PF_FETCH;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= inflight_d;
    end
  end

  // Clear outranks push, so a byte returning during a flush is dropped
  pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_i (bus.flush),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .data_i  (bus.mem_i_data),
    .data_o  (bus.q_data),
    .count_o (count)
  );

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_flush_q, stat_starve_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_flush_q  <= '0;
      stat_starve_q <= '0;
    end else begin
      if (bus.flush && (stat_flush_q != 16'hFFFF))
        stat_flush_q <= stat_flush_q + 16'd1;
      if (bus.q_ready && !bus.q_valid && (stat_starve_q != 16'hFFFF))
        stat_starve_q <= stat_starve_q + 16'd1;
    end
  end

  assign stat_flush  = stat_flush_q;
  assign stat_starve = stat_starve_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_x86_prefetch_queue.sv
// ============================================================================
// tb_x86_prefetch_queue : directed stimulus, queue-level model, literal pins
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_x86_prefetch_queue;
  localparam int DEPTH = 6;
  localparam int AW    = 20;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  x86_prefetch_queue_if #(.AW(AW)) bus ();

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_flush, stat_starve;
`endif

  x86_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_flush  (stat_flush),
    .stat_starve (stat_starve)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    case (a)
      20'h00100: return 8'h90;
      20'h00101: return 8'hB8;
      20'h00102: return 8'h34;
      20'h00103: return 8'h12;
      default:   return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  // Synchronous-read memory, one cycle latency
  always @(posedge clock) bus.mem_i_data <= mem_byte(bus.mem_address);

  // Queue-level model: byte FIFO, fetch pointer, one outstanding read, grant bit
  logic [7:0]    m_q[$];
  logic [AW-1:0] m_fa, m_inf_addr;
  bit            m_inf, m_gnt, m_issue, m_arrive, m_pop;
  int            m_flush, m_starve;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_fa = '0; m_inf_addr = '0; m_inf = 0; m_gnt = 0;
      m_flush = 0; m_starve = 0;
    end else begin
      m_issue  = !m_gnt && !bus.eu_req && !bus.flush && (m_q.size() + int'(m_inf) < DEPTH);
      m_arrive = m_inf && !bus.flush;
      m_pop    = bus.q_ready && (m_q.size() > 0);
      if (bus.flush && m_flush < 65535) m_flush++;
      if (bus.q_ready && m_q.size() == 0 && m_starve < 65535) m_starve++;
      if (bus.flush) begin
        m_q.delete();
        m_fa = bus.flush_addr;
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_arrive) m_q.push_back(mem_byte(m_inf_addr));
      end
      if (!m_gnt) m_gnt = bus.eu_req && !m_inf;
      else        m_gnt = bus.eu_req;
      if (m_issue) begin
        m_inf_addr = m_fa;
        m_fa = m_fa + 20'd1;
      end
      m_inf = m_issue;
    end
  end

  always @(negedge clock) begin
    #1;
    if (reset_n && checking) begin
      check("q_valid", bus.q_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("q_data", bus.q_data, m_q[0]);
      check("eu_gnt", bus.eu_gnt, m_gnt);
      check("mem_address", bus.mem_address, m_gnt ? bus.eu_address : m_fa);
`ifdef PREFETCH_STATS_EN
      check("stat_flush", stat_flush, m_flush);
      check("stat_starve", stat_starve, m_starve);
`endif
    end
  end

  logic [7:0]    exp_p1 [4] = '{8'h90, 8'hB8, 8'h34, 8'h12};
  logic [AW-1:0] exp_p5 [4] = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};

  initial begin
    bus.flush = 0; bus.flush_addr = '0; bus.q_ready = 0;
    bus.eu_req = 0; bus.eu_address = '0;
    #1 reset_n = 0;
    repeat (3) @(negedge clock);
    reset_n = 1;
    #2;
    check("reset_q_valid", bus.q_valid, 1'b0);
    check("reset_eu_gnt", bus.eu_gnt, 1'b0);
    check("reset_mem_address", bus.mem_address, 20'h00000);
    checking = 1'b1;

    // Stream from 0x100 with the decoder always ready
    @(negedge clock); bus.flush = 1; bus.flush_addr = 20'h00100; bus.q_ready = 1;
    @(negedge clock); bus.flush = 0;
    #2 check("p1_first_fetch", bus.mem_address, 20'h00100);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      #2;
      check("p1_valid", bus.q_valid, 1'b1);
      check("p1_data", bus.q_data, exp_p1[i]);
      @(negedge clock);
    end

    // Fill with the decoder stalled: six fetches then hold at 0x106
    bus.flush = 1; bus.flush_addr = 20'h00100; bus.q_ready = 0;
    @(negedge clock); bus.flush = 0;
    repeat (10) @(negedge clock);
    #2;
    check("p2_hold_addr", bus.mem_address, 20'h00106);
    check("p2_valid", bus.q_valid, 1'b1);
    check("p2_head", bus.q_data, 8'h90);

    // Single pop from a full queue
    @(negedge clock); bus.q_ready = 1;
    @(negedge clock); bus.q_ready = 0;
    #2 check("p3_after_pop", bus.q_data, 8'hB8);
    repeat (3) @(negedge clock);

    // Flush to 0x200 while the 0x103 read is returning
    bus.flush = 1; bus.flush_addr = 20'h00100; bus.q_ready = 0;
    @(negedge clock); bus.flush = 0;
    repeat (4) @(negedge clock);
    bus.flush = 1; bus.flush_addr = 20'h00200;
    @(negedge clock); bus.flush = 0;
    #2 check("p4_empty_c6", bus.q_valid, 1'b0);
    @(negedge clock);
    #2 check("p4_empty_c7", bus.q_valid, 1'b0);
    @(negedge clock);
    #2;
    check("p4_valid", bus.q_valid, 1'b1);
    check("p4_data_200", bus.q_data, 8'hA7);
    bus.q_ready = 1;
    @(negedge clock);
    #2 check("p4_data_201", bus.q_data, 8'hA6);

    // Address wrap at the top of the 1 MB space
    @(negedge clock); bus.flush = 1; bus.flush_addr = 20'hFFFFE; bus.q_ready = 0;
    @(negedge clock); bus.flush = 0;
    for (int i = 0; i < 4; i++) begin
      #2 check("p5_wrap_addr", bus.mem_address, exp_p5[i]);
      @(negedge clock);
    end

    // EU request while the 0x00001 read is in flight
    bus.eu_req = 1; bus.eu_address = 20'h12345;
    #2 check("p6_gnt_c0", bus.eu_gnt, 1'b0);
    @(negedge clock);
    #2;
    check("p6_gnt_c1", bus.eu_gnt, 1'b0);
    check("p6_addr_c1", bus.mem_address, 20'h00002);
    @(negedge clock);
    #2;
    check("p6_gnt_c2", bus.eu_gnt, 1'b1);
    check("p6_eu_addr", bus.mem_address, 20'h12345);
    repeat (2) begin
      @(negedge clock);
      #2 check("p6_gnt_hold", bus.eu_gnt, 1'b1);
    end
    @(negedge clock); bus.eu_req = 0;
    #2 check("p6_gnt_release", bus.eu_gnt, 1'b1);
    @(negedge clock);
    #2;
    check("p6_gnt_off", bus.eu_gnt, 1'b0);
    check("p6_resume", bus.mem_address, 20'h00002);
    check("p6_head", bus.q_data, 8'hA4);

    // Flush together with eu_req, then a flush during the grant
    @(negedge clock);
    bus.flush = 1; bus.flush_addr = 20'h00300; bus.eu_req = 1; bus.eu_address = 20'h0ABCD;
    @(negedge clock); bus.flush = 0;
    repeat (3) @(negedge clock);
    bus.flush = 1; bus.flush_addr = 20'h00400; bus.q_ready = 1;
    @(negedge clock); bus.flush = 0;
    #2;
    check("p7_gnt_kept", bus.eu_gnt, 1'b1);
    check("p7_empty", bus.q_valid, 1'b0);
    repeat (2) @(negedge clock);
    bus.eu_req = 0;
    repeat (8) @(negedge clock);

    // Asynchronous reset while bytes are queued and the EU holds the port
    bus.q_ready = 0;
    repeat (4) @(negedge clock);
    bus.eu_req = 1; bus.eu_address = 20'h55555;
    repeat (3) @(negedge clock);
    #2;
    check("p8_pre_gnt", bus.eu_gnt, 1'b1);
    check("p8_pre_valid", bus.q_valid, 1'b1);
`ifdef PREFETCH_STATS_EN
    check("p8_pre_stat_flush", stat_flush, 16'd7);
`endif
    #1 reset_n = 0;
    #1;
    check("p8_rst_valid", bus.q_valid, 1'b0);
    check("p8_rst_gnt", bus.eu_gnt, 1'b0);
    check("p8_rst_addr", bus.mem_address, 20'h00000);
`ifdef PREFETCH_STATS_EN
    check("p8_rst_stat_flush", stat_flush, 16'd0);
    check("p8_rst_stat_starve", stat_starve, 16'd0);
`endif
    @(negedge clock); bus.eu_req = 0;
    @(negedge clock); reset_n = 1; bus.q_ready = 1;
    repeat (12) @(negedge clock);

    #3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
